// File: rtl/fifo_rd_ctrl.sv
// ============================================================================
// fifo_rd_ctrl : async FIFO read-side pointer / flag controller (read domain)
// Rev 1.0
// ============================================================================
`default_nettype none

module fifo_rd_ctrl #(
  parameter int ADDR_WIDTH = 3,
  parameter int AE_THRESH  = 1
) (
  input  logic                  r_clk,
  input  logic                  r_rst,
  input  logic                  r_inc,
  input  logic [ADDR_WIDTH:0]   sync_wr_ptr,
  input  logic                  clr_underflow,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_en,
  output logic [ADDR_WIDTH:0]   gray_rd_ptr,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   rd_level,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] AE_LIMIT = (ADDR_WIDTH+1)'(AE_THRESH);

  logic [ADDR_WIDTH:0] bin_ptr;
  logic [ADDR_WIDTH:0] bin_next;
  logic [ADDR_WIDTH:0] gray_next;
  logic [ADDR_WIDTH:0] wr_bin;
  logic [ADDR_WIDTH:0] level_next;
  logic                acc;

  assign acc       = r_inc & ~empty;
  assign bin_next  = bin_ptr + {{ADDR_WIDTH{1'b0}}, acc};
  assign gray_next = bin_next ^ (bin_next >> 1);

  // Gray-to-binary: each binary bit is the XOR of all Gray bits from the MSB down.
  genvar i;
  generate
    for (i = 0; i <= ADDR_WIDTH; i++) begin : g_g2b
      assign wr_bin[i] = ^sync_wr_ptr[ADDR_WIDTH:i];
    end
  endgenerate

  assign level_next = wr_bin - bin_next;
  assign rd_addr    = bin_ptr[ADDR_WIDTH-1:0];
  assign rd_en      = acc;

  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      bin_ptr      <= '0;
      gray_rd_ptr  <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      rd_level     <= '0;
      underflow    <= 1'b0;
    end else begin
      bin_ptr      <= bin_next;
      gray_rd_ptr  <= gray_next;
      empty        <= (gray_next == sync_wr_ptr);
      rd_level     <= level_next;
      almost_empty <= (level_next <= AE_LIMIT);
      // A new underflow takes priority over a simultaneous clear.
      if (r_inc & empty)
        underflow <= 1'b1;
      else if (clr_underflow)
        underflow <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_ctrl.sv
// ============================================================================
// tb_fifo_rd_ctrl : scoreboard bench for fifo_rd_ctrl (AE_THRESH 1 and 3)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fifo_rd_ctrl;

  logic       r_clk = 1'b0;
  logic       r_rst;
  logic       r_inc;
  logic [3:0] sync_wr_ptr;
  logic       clr_underflow;

  logic [2:0] rd_addr,  rd_addr3;
  logic       rd_en,    rd_en3;
  logic [3:0] gray_rd_ptr, gray_rd_ptr3;
  logic       empty,    empty3;
  logic       almost_empty, almost_empty3;
  logic [3:0] rd_level, rd_level3;
  logic       underflow, underflow3;

  fifo_rd_ctrl #(.ADDR_WIDTH(3), .AE_THRESH(1)) u_dut (
    .r_clk(r_clk), .r_rst(r_rst), .r_inc(r_inc), .sync_wr_ptr(sync_wr_ptr),
    .clr_underflow(clr_underflow), .rd_addr(rd_addr), .rd_en(rd_en),
    .gray_rd_ptr(gray_rd_ptr), .empty(empty), .almost_empty(almost_empty),
    .rd_level(rd_level), .underflow(underflow)
  );

  fifo_rd_ctrl #(.ADDR_WIDTH(3), .AE_THRESH(3)) u_dut_ae3 (
    .r_clk(r_clk), .r_rst(r_rst), .r_inc(r_inc), .sync_wr_ptr(sync_wr_ptr),
    .clr_underflow(clr_underflow), .rd_addr(rd_addr3), .rd_en(rd_en3),
    .gray_rd_ptr(gray_rd_ptr3), .empty(empty3), .almost_empty(almost_empty3),
    .rd_level(rd_level3), .underflow(underflow3)
  );

  always #5 r_clk = ~r_clk;

  typedef struct packed {
    logic [3:0] gray;
    logic       empty;
    logic       ae;
    logic       ae3;
    logic [3:0] level;
    logic       uf;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state
  logic [3:0] m_bin;
  logic       m_empty;
  logic       m_uf;
  int         wcnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] to_gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [3:0] from_gray(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int k = 2; k >= 0; k--) b[k] = b[k+1] ^ g[k];
    return b;
  endfunction

  task automatic model_reset();
    m_bin   = 4'd0;
    m_empty = 1'b1;
    m_uf    = 1'b0;
    wcnt    = 0;
  endtask

  // Drive one cycle of stimulus, push the expected post-edge state, compare it after the edge.
  task automatic step(input bit inc, input bit clr);
    logic       acc;
    logic [3:0] nb, wb, lvl;
    exp_t       e, got_e;
    @(negedge r_clk);
    r_inc         = inc;
    sync_wr_ptr   = to_gray(4'(wcnt));
    clr_underflow = clr;
    #1;
    chk("rd_en",    32'(rd_en),    32'(inc & ~m_empty));
    chk("rd_addr",  32'(rd_addr),  32'(m_bin[2:0]));
    chk("rd_en3",   32'(rd_en3),   32'(inc & ~m_empty));
    chk("rd_addr3", 32'(rd_addr3), 32'(m_bin[2:0]));
    acc     = inc & ~m_empty;
    nb      = m_bin + 4'(acc);
    wb      = from_gray(sync_wr_ptr);
    lvl     = wb - nb;
    e.gray  = to_gray(nb);
    e.empty = (nb == wb);
    e.level = lvl;
    e.ae    = (lvl <= 4'd1);
    e.ae3   = (lvl <= 4'd3);
    e.uf    = (inc & m_empty) ? 1'b1 : (clr ? 1'b0 : m_uf);
    q.push_back(e);
    m_bin   = nb;
    m_empty = e.empty;
    m_uf    = e.uf;
    @(posedge r_clk);
    #1;
    if (q.size() == 0) begin
      chk("queue_nonempty", 32'(0), 32'(1));
    end else begin
      got_e = q.pop_front();
      chk("gray_rd_ptr",   32'(gray_rd_ptr),   32'(got_e.gray));
      chk("empty",         32'(empty),         32'(got_e.empty));
      chk("rd_level",      32'(rd_level),      32'(got_e.level));
      chk("almost_empty",  32'(almost_empty),  32'(got_e.ae));
      chk("underflow",     32'(underflow),     32'(got_e.uf));
      chk("gray_rd_ptr3",  32'(gray_rd_ptr3),  32'(got_e.gray));
      chk("empty3",        32'(empty3),        32'(got_e.empty));
      chk("rd_level3",     32'(rd_level3),     32'(got_e.level));
      chk("almost_empty3", 32'(almost_empty3), 32'(got_e.ae3));
      chk("underflow3",    32'(underflow3),    32'(got_e.uf));
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_empty"}, 32'(empty),        32'(1));
    chk({tag, "_ae"},    32'(almost_empty), 32'(1));
    chk({tag, "_level"}, 32'(rd_level),     32'(0));
    chk({tag, "_gray"},  32'(gray_rd_ptr),  32'(0));
    chk({tag, "_uf"},    32'(underflow),    32'(0));
    chk({tag, "_addr"},  32'(rd_addr),      32'(0));
    chk({tag, "_rd_en"}, 32'(rd_en),        32'(0));
    chk({tag, "_ae3"},   32'(almost_empty3), 32'(1));
  endtask

  initial begin
    r_rst         = 1'b1;
    r_inc         = 1'b0;
    sync_wr_ptr   = 4'd0;
    clr_underflow = 1'b0;
    model_reset();
    #12;
    check_reset_state("por");
    @(negedge r_clk);
    r_rst = 1'b0;

    // Underflow: read while empty, set beats clear, then clear alone
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);

    // Fill to 3 entries, then drain with back-to-back reads
    for (int k = 0; k < 3; k++) begin
      wcnt++;
      step(1'b0, 1'b0);
    end
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0);

    // Lockstep write/read across the pointer wrap
    wcnt++;
    step(1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      wcnt = (wcnt + 1) % 16;
      step(1'b1, 1'b0);
    end
    step(1'b1, 1'b0);

    // Set underflow and leave some level, then reset mid-cycle
    step(1'b1, 1'b0);
    wcnt = (wcnt + 2) % 16;
    step(1'b0, 1'b0);
    #2;
    r_rst         = 1'b1;
    r_inc         = 1'b0;
    sync_wr_ptr   = 4'd0;
    clr_underflow = 1'b0;
    #1;
    check_reset_state("async_rst");
    @(negedge r_clk);
    @(negedge r_clk);
    r_rst = 1'b0;
    model_reset();

    // Full level, then drain through the AE_THRESH=3 boundary to empty
    wcnt = 8;
    step(1'b0, 1'b0);
    for (int k = 0; k < 8; k++) step(1'b1, 1'b0);
    step(1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
Parametrised read-side pointer/flag controller for the async FIFO, in the read clock domain. Keeps the binary and Gray read pointers, drives the RAM read address and read enable, and compares against the synchronised Gray write pointer. It produces registered empty, almost-empty and fill-level outputs plus a sticky underflow error.
Depth and threshold are parameters. Empty resets asserted.

Parameters:
ADDR_WIDTH, 3, RAM address width; FIFO depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits
AE_THRESH, 1, almost_empty asserts when fill level <= AE_THRESH (legal 0..2**ADDR_WIDTH-1)

Ports:
r_clk  in  1  read-domain clock
r_rst  in  1  asynchronous active-high reset
r_inc  in  1  read request from consumer
sync_wr_ptr  in  ADDR_WIDTH+1  Gray write pointer, already 2-FF synchronised into r_clk
clr_underflow  in  1  clears sticky underflow
rd_addr  out  ADDR_WIDTH  RAM read address = binary read pointer LSBs
rd_en  out  1  RAM read enable = r_inc & ~empty (combinational)
gray_rd_ptr  out  ADDR_WIDTH+1  registered Gray read pointer, to write-domain synchroniser
empty  out  1  registered empty flag
almost_empty  out  1  registered, level <= AE_THRESH
rd_level  out  ADDR_WIDTH+1  registered conservative fill level, 0..2**ADDR_WIDTH
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Single clock r_clk. r_rst is asynchronous, active-high. All state is cleared on assertion; release is synchronous to r_clk (external reset synchroniser).
- Reset values: binary ptr 0, gray_rd_ptr 0, empty 1, almost_empty 1, rd_level 0, underflow 0; rd_addr 0, rd_en 0.
- Accept: acc = r_inc & ~empty. bin_next = bin + acc, mod 2**(ADDR_WIDTH+1), wraps naturally. gray_next = bin_next ^ (bin_next >> 1).
- Each clock: bin <= bin_next; gray_rd_ptr <= gray_next.
- Each clock: empty <= (gray_next == sync_wr_ptr).
- Write-pointer binary: wr_bin = Gray-to-binary(sync_wr_ptr) via an XOR prefix chain from the MSB. Combinational only; no registering of sync_wr_ptr inside the block.
- Level: level_next = (wr_bin - bin_next) mod 2**(ADDR_WIDTH+1). rd_level <= level_next; almost_empty <= (level_next <= AE_THRESH).
- rd_addr = bin[ADDR_WIDTH-1:0]. Read data is valid from RAM per the RAM's own latency; this block adds none.
- Latency: read accepted at edge N -> gray_rd_ptr, rd_level, empty and almost_empty reflect it after edge N. A new write becomes visible only after sync_wr_ptr changes, plus one r_clk.
- Flags are pessimistic: empty and almost_empty may stay asserted after a write until it is synchronised; they never falsely deassert.
- Underflow: r_inc & empty sets underflow at the next edge. The pointer does not move and rd_en stays 0. clr_underflow clears it. A set and a clear in the same cycle -> set wins. Held until r_rst or clr_underflow.
- Wrap-around: the pointer MSB toggles every 2**ADDR_WIDTH reads. Empty means full Gray equality including the MSB. A full FIFO gives level = 2**ADDR_WIDTH.
- Reset mid-operation: pointers return to 0 immediately (async). The write side must be reset concurrently; this is a system requirement, not checked here.
- sync_wr_ptr is assumed legal Gray (one bit change per write). There is no special handling for multi-bit jumps.

Test Plan:
- Reset: assert r_rst mid-clock -> empty=1, almost_empty=1, rd_level=0, gray_rd_ptr=0, underflow=0 immediately, without waiting for a clock edge.
- Fill and drain (ADDR_WIDTH=3): step sync_wr_ptr Gray 0->1->3->2 (wr_bin=3). -> Next edge: empty=0, rd_level=3, almost_empty=0. Then 3 back-to-back r_inc: rd_addr 0,1,2. -> rd_level 2,1,0; almost_empty=1 after level 1; empty=1 after the 3rd read; gray_rd_ptr=2.
- Underflow: empty=1, pulse r_inc -> rd_en=0, pointer unchanged, underflow=1 next edge. clr_underflow together with r_inc -> underflow stays 1. clr_underflow alone -> underflow 0.
- Wrap: write/read 20 entries in lockstep -> bin wraps 15->0 (gray 8->0). rd_addr cycles 0..7. Empty asserts exactly when the pointers match; no false empty at the MSB toggle.
- Full level: sync_wr_ptr = Gray(8)=4'b1100 with read ptr 0 -> rd_level=8, empty=0, almost_empty=0.
- Threshold: AE_THRESH=3, level 4 -> almost_empty=0. One read -> level 3 -> almost_empty=1 on the same edge.
